relu_maxpool_stream: RTL and testbench



---
 rtl/conv_pkg.sv | 39 +++
 rtl/maxpool_row_buf.sv | 36 +++
 rtl/relu_maxpool_stream.sv | 148 ++++++++++++++
 tb/tb_relu_maxpool_stream.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg
//   Shared definitions for the conv2d block and its downstream stages.
//   - CONV_DATA_WIDTH : default element width of the conv datapath.
//   - MAX_W           : working width for max2; callers sign-extend into it.
//   - POOL_K/POOL_S   : 2x2 window, stride 2, for the pooling stage.
//   - win_pos_e       : where an input beat falls inside a 2x2 pooling window.
//   - max2()          : signed maximum of two values.
//   - out_size()      : output extent (H - K)/S + 1 of a windowed operator.
package conv_pkg;

   localparam int unsigned CONV_DATA_WIDTH = 32;
   localparam int unsigned MAX_W           = 64;
   localparam int unsigned POOL_K          = 2;
   localparam int unsigned POOL_S          = 2;

   typedef enum logic [2:0] {
      WIN_TOP_L,
      WIN_TOP_R,
      WIN_BOT_L,
      WIN_BOT_R,
      WIN_SKIP
   } win_pos_e;

   function automatic logic signed [MAX_W-1:0] max2(
      input logic signed [MAX_W-1:0] a,
      input logic signed [MAX_W-1:0] b
   );
      return (a > b) ? a : b;
   endfunction

   function automatic int unsigned out_size(
      input int unsigned h,
      input int unsigned k,
      input int unsigned s
   );
      return (h - k) / s + 1;
   endfunction

endpackage

// File: rtl/maxpool_row_buf.sv
// maxpool_row_buf
//   Row buffer of partial (horizontal) maxima for the 2x2 max-pool stage.
//   Written on even input rows, read on the following odd row at the same
//   window column. Contents need no reset: every entry is rewritten on an
//   even row before it is read.
// Ports:
//   clk     : clock
//   wr_en   : write strobe
//   wr_idx  : write entry (col>>1)
//   wr_data : partial maximum to store
//   rd_idx  : read entry (col>>1)
//   rd_data : stored partial maximum (combinational read)
module maxpool_row_buf #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 1,
   parameter int unsigned IDX_W      = 1
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   always_comb rd_data = mem[rd_idx];

endmodule

// File: rtl/relu_maxpool_stream.sv
// relu_maxpool_stream
//   Streaming ReLU followed by 2x2 / stride-2 max pooling. Consumes conv
//   output elements in flat order (channel, row, column; column fastest) and
//   produces pooled elements through a single-entry output register.
// Ports:
//   clk       : clock, all state on rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : upstream element valid
//   in_ready  : stage can accept an element
//   in_data   : conv output element, signed
//   out_valid : pooled element valid
//   out_ready : downstream can accept
//   out_data  : pooled element, signed
//   out_last  : final pooled element of a frame
module relu_maxpool_stream
   import conv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = CONV_DATA_WIDTH,
   parameter int unsigned CHANNELS   = 1,
   parameter int unsigned IN_HEIGHT  = 2,
   parameter int unsigned IN_WIDTH   = 2,
   parameter bit          RELU_EN    = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] out_data,
   output logic                         out_last
);

   localparam int unsigned P_W   = out_size(IN_WIDTH, POOL_K, POOL_S);
   localparam int unsigned P_H   = out_size(IN_HEIGHT, POOL_K, POOL_S);
   localparam int unsigned COL_W = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
   localparam int unsigned ROW_W = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
   localparam int unsigned CH_W  = (CHANNELS  > 1) ? $clog2(CHANNELS)  : 1;
   localparam int unsigned IDX_W = (P_W       > 1) ? $clog2(P_W)       : 1;

   function automatic logic signed [DATA_WIDTH-1:0] smax(
      input logic signed [DATA_WIDTH-1:0] a,
      input logic signed [DATA_WIDTH-1:0] b
   );
      return DATA_WIDTH'(max2(MAX_W'(a), MAX_W'(b)));
   endfunction

   logic [COL_W-1:0]             col;
   logic [ROW_W-1:0]             row;
   logic [CH_W-1:0]              ch;
   logic signed [DATA_WIDTH-1:0] h_max;
   logic signed [DATA_WIDTH-1:0] x;
   logic signed [DATA_WIDTH-1:0] pair_max;
   logic signed [DATA_WIDTH-1:0] win_max;
   logic [DATA_WIDTH-1:0]        buf_rd;
   logic [IDX_W-1:0]             buf_idx;
   win_pos_e                     pos;
   logic                         accept;
   logic                         buf_wr;
   logic                         col_end;
   logic                         row_end;
   logic                         ch_end;
   logic                         last_nxt;

   always_comb in_ready = rst_n && (!out_valid || out_ready);
   always_comb accept   = in_valid && in_ready;

   // Sign bit set means the element is negative.
   always_comb x = (RELU_EN && in_data[DATA_WIDTH-1]) ? '0 : in_data;

   // Beats in odd trailing columns/rows fall outside every window.
   always_comb begin
      pos = WIN_SKIP;
      if ((32'(col) < 2 * P_W) && (32'(row) < 2 * P_H)) begin
         unique case ({row[0], col[0]})
            2'b00:   pos = WIN_TOP_L;
            2'b01:   pos = WIN_TOP_R;
            2'b10:   pos = WIN_BOT_L;
            default: pos = WIN_BOT_R;
         endcase
      end
   end

   always_comb begin
      buf_idx  = IDX_W'(col >> 1);
      buf_wr   = accept && (pos == WIN_TOP_R);
      pair_max = smax(h_max, x);
      win_max  = smax(buf_rd, pair_max);
      col_end  = (32'(col) == IN_WIDTH - 1);
      row_end  = (32'(row) == IN_HEIGHT - 1);
      ch_end   = (32'(ch) == CHANNELS - 1);
      last_nxt = ch_end && (32'(row) == 2 * P_H - 1) && (32'(col) == 2 * P_W - 1);
   end

   maxpool_row_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (P_W),
      .IDX_W      (IDX_W)
   ) u_row_buf (
      .clk     (clk),
      .wr_en   (buf_wr),
      .wr_idx  (buf_idx),
      .wr_data (pair_max),
      .rd_idx  (buf_idx),
      .rd_data (buf_rd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col       <= '0;
         row       <= '0;
         ch        <= '0;
         h_max     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         if (accept) begin
            if (pos == WIN_TOP_L || pos == WIN_BOT_L) begin
               h_max <= x;
            end
            if (col_end) begin
               col <= '0;
               if (row_end) begin
                  row <= '0;
                  ch  <= ch_end ? '0 : ch + CH_W'(1);
               end else begin
                  row <= row + ROW_W'(1);
               end
            end else begin
               col <= col + COL_W'(1);
            end
         end

         // A producing beat reloads the register even while it is being
         // drained; otherwise a drain simply empties it.
         if (accept && pos == WIN_BOT_R) begin
            out_valid <= 1'b1;
            out_data  <= win_max;
            out_last  <= last_nxt;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_relu_maxpool_stream.sv
module tb_relu_maxpool_stream;

   typedef struct {
      logic signed [31:0] d;
      logic               l;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   int n_vec = 0;
   int n_err = 0;

   // Instances A and B (2x2, ReLU on/off) share their input side.
   logic               iv_ab, or_ab, ir_a, ir_b, ov_a, ov_b, ol_a, ol_b;
   logic signed [31:0] id_ab, od_a, od_b;
   // Instance C: 4x4, 2 channels.
   logic               iv_c, or_c, ir_c, ov_c, ol_c;
   logic signed [31:0] id_c, od_c;
   // Instance D: 3x3, 1 channel.
   logic               iv_d, or_d, ir_d, ov_d, ol_d;
   logic signed [31:0] id_d, od_d;

   exp_t q_a[$], q_b[$], q_c[$], q_d[$];
   int   cnt_a = 0, cnt_b = 0, cnt_c = 0, cnt_d = 0;

   relu_maxpool_stream #(.DATA_WIDTH(32), .CHANNELS(1), .IN_HEIGHT(2), .IN_WIDTH(2), .RELU_EN(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_ab), .in_ready(ir_a), .in_data(id_ab),
      .out_valid(ov_a), .out_ready(or_ab), .out_data(od_a), .out_last(ol_a));

   relu_maxpool_stream #(.DATA_WIDTH(32), .CHANNELS(1), .IN_HEIGHT(2), .IN_WIDTH(2), .RELU_EN(1'b0)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_ab), .in_ready(ir_b), .in_data(id_ab),
      .out_valid(ov_b), .out_ready(or_ab), .out_data(od_b), .out_last(ol_b));

   relu_maxpool_stream #(.DATA_WIDTH(32), .CHANNELS(2), .IN_HEIGHT(4), .IN_WIDTH(4), .RELU_EN(1'b1)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .in_ready(ir_c), .in_data(id_c),
      .out_valid(ov_c), .out_ready(or_c), .out_data(od_c), .out_last(ol_c));

   relu_maxpool_stream #(.DATA_WIDTH(32), .CHANNELS(1), .IN_HEIGHT(3), .IN_WIDTH(3), .RELU_EN(1'b1)) u_d (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_d), .in_ready(ir_d), .in_data(id_d),
      .out_valid(ov_d), .out_ready(or_d), .out_data(od_d), .out_last(ol_d));

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic pop_chk(input string name, inout exp_t q[$], input logic signed [31:0] d, input logic l);
      exp_t e;
      if (q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_unexpected: got data %0d last %0b, expected no output", name, d, l);
      end else begin
         e = q.pop_front();
         chk({name, "_data"}, d, e.d);
         chk({name, "_last"}, l, e.l);
      end
   endtask

   // Scoreboard monitors: sampled mid-cycle, a transfer happens at the next rising edge.
   always @(negedge clk) begin
      if (rst_n && ov_a && or_ab) begin cnt_a++; pop_chk("a", q_a, od_a, ol_a); end
      if (rst_n && ov_b && or_ab) begin cnt_b++; pop_chk("b", q_b, od_b, ol_b); end
      if (rst_n && ov_c && or_c)  begin cnt_c++; pop_chk("c", q_c, od_c, ol_c); end
      if (rst_n && ov_d && or_d)  begin cnt_d++; pop_chk("d", q_d, od_d, ol_d); end
   end

   function automatic logic ready(input int dut);
      case (dut)
         0:       return ir_a && ir_b;
         1:       return ir_c;
         default: return ir_d;
      endcase
   endfunction

   function automatic exp_t mk(input logic signed [31:0] d, input logic l);
      exp_t e;
      e.d = d;
      e.l = l;
      return e;
   endfunction

   // Presents one beat and returns 1 time unit after the accepting edge.
   task automatic send(input int dut, input logic signed [31:0] v);
      int n = 0;
      case (dut)
         0:       begin iv_ab = 1'b1; id_ab = v; end
         1:       begin iv_c  = 1'b1; id_c  = v; end
         default: begin iv_d  = 1'b1; id_d  = v; end
      endcase
      @(negedge clk);
      while (!ready(dut)) begin
         n++;
         if (n > 200) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: dut %0d value %0d not accepted, expected accept within 200 cycles", dut, v);
            return;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      iv_ab = 1'b0;
      iv_c  = 1'b0;
      iv_d  = 1'b0;
   endtask

   task automatic push_c_frame();
      q_c.push_back(mk(5, 0));  q_c.push_back(mk(7, 0));
      q_c.push_back(mk(13, 0)); q_c.push_back(mk(15, 0));
      q_c.push_back(mk(21, 0)); q_c.push_back(mk(23, 0));
      q_c.push_back(mk(29, 0)); q_c.push_back(mk(31, 1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      int unsigned t0;
      iv_ab = 0; id_ab = 0; or_ab = 1;
      iv_c  = 0; id_c  = 0; or_c  = 1;
      iv_d  = 0; id_d  = 0; or_d  = 1;

      // Reset state
      #12;
      chk("rst_a_valid", ov_a, 0);
      chk("rst_a_data",  od_a, 0);
      chk("rst_a_last",  ol_a, 0);
      chk("rst_a_ready", ir_a, 0);
      chk("rst_c_valid", ov_c, 0);
      chk("rst_c_ready", ir_c, 0);
      chk("rst_d_valid", ov_d, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("a_ready_after_rst", ir_a, 1);

      // 2x2: 3, -5, 7, 1 -> 7 on both, one cycle after the 4th beat
      q_a.push_back(mk(7, 1));
      q_b.push_back(mk(7, 1));
      send(0, 3); send(0, -5); send(0, 7);
      chk("ab_early_valid", ov_a, 0);
      send(0, 1);
      chk("a_latency_valid", ov_a, 1);
      chk("b_latency_valid", ov_b, 1);
      idle_all();
      repeat (3) @(posedge clk); #1;
      chk("a_count_1", cnt_a, 1);
      chk("b_count_1", cnt_b, 1);

      // All negative: ReLU on -> 0, ReLU off -> -1
      q_a.push_back(mk(0, 1));
      q_b.push_back(mk(-1, 1));
      send(0, -1); send(0, -2); send(0, -3); send(0, -4);
      idle_all();
      repeat (3) @(posedge clk); #1;
      chk("a_count_2", cnt_a, 2);
      chk("b_count_2", cnt_b, 2);

      // 3x3 values 1..9 -> single 5; trailing column/row discarded
      q_d.push_back(mk(5, 1));
      for (int v = 1; v <= 9; v++) begin
         send(2, v);
         if (v >= 6) chk($sformatf("d_no_out_after_%0d", v), ov_d, 0);
      end
      // Next frame reversed 9..1 -> window (9,8,6,5) -> 9
      q_d.push_back(mk(9, 1));
      for (int v = 9; v >= 1; v--) send(2, v);
      idle_all();
      repeat (3) @(posedge clk); #1;
      chk("d_count", cnt_d, 2);

      // 4x4 x2 channels with backpressure after the first output
      push_c_frame();
      for (int v = 0; v <= 5; v++) send(1, v);
      or_c = 1'b0;
      chk("c_first_valid", ov_c, 1);
      fork
         for (int v = 6; v <= 31; v++) send(1, v);
         begin
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               chk("c_bp_in_ready", ir_c, 0);
               chk("c_bp_hold_data", od_c, 5);
            end
            @(posedge clk); #1 or_c = 1'b1;
         end
      join
      idle_all();
      repeat (3) @(posedge clk); #1;
      chk("c_count_bp", cnt_c, 8);

      // Full throughput: 32 beats on 32 consecutive edges
      push_c_frame();
      send(1, 0);
      t0 = cyc;
      for (int v = 1; v <= 31; v++) send(1, v);
      chk("c_throughput_cycles", cyc - t0, 31);
      idle_all();
      repeat (3) @(posedge clk); #1;
      chk("c_count_tp", cnt_c, 16);

      // Reset after 6 beats; partial frame is dropped
      for (int v = 0; v <= 5; v++) send(1, v);
      idle_all();
      chk("c_pre_reset_valid", ov_c, 1);
      rst_n = 1'b0;
      #1;
      chk("c_reset_valid", ov_c, 0);
      chk("c_reset_ready", ir_c, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      push_c_frame();
      for (int v = 0; v <= 31; v++) send(1, v);
      idle_all();
      repeat (3) @(posedge clk); #1;
      chk("c_count_post_reset", cnt_c, 24);

      chk("q_a_empty", q_a.size(), 0);
      chk("q_b_empty", q_b.size(), 0);
      chk("q_c_empty", q_c.size(), 0);
      chk("q_d_empty", q_d.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
